ring_switch_allocator: RTL and testbench
========================================

Name: ring_switch_allocator

Overview:
- Per-cycle switch allocator for the 3-port ring router. It generates the one-hot select words that drive the router crossbar (sel0..sel2, 5 bits each), and returns grants to the input buffers.
- Each input requests one output port per cycle. Each output runs its own round-robin arbiter with wormhole locking, held from the head flit to the tail flit.
- The allocator sits between the input FIFOs/route compute and the registered crossbar.

Parameters:
- SEL_W, 5: width of each select output. Only bits [2:0] are used; bits [SEL_W-1:3] are driven 0.
- CNT_W, 16: width of the stall counters (optional feature only).

Ports:
- clk  in  1  router clock
- rst  in  1  synchronous, active-low reset, sampled on posedge clk
- req0, req1, req2  in  1 each  input k holds a valid flit
- dst0, dst1, dst2  in  2 each  requested output port of input k (0..2); value 3 is illegal
- tail0, tail1, tail2  in  1 each  current flit of input k is the tail (a single-flit packet asserts head and tail together)
- out_rdy0, out_rdy1, out_rdy2  in  1 each  downstream of output o can accept a flit this cycle
- sel0, sel1, sel2  out  SEL_W each  registered one-hot crossbar select; bit k = source input k; all-zero = idle
- gnt0, gnt1, gnt2  out  1 each  registered; flit on input k is transferred this cycle
- dst_err  out  1  registered one-cycle pulse: some input asserted req with dst==3

Behaviour:
- Reset (rst==0 at posedge): sel*=0, gnt*=0, dst_err=0, all round-robin pointers ptr_o=0, all outputs unlocked.
  - Reset mid-packet drops every lock; no partial-packet recovery.
- Latency: inputs are sampled at edge t; sel/gnt are valid in cycle t+1.
  - The source holds its flit and req until it sees gnt_k high.
  - The crossbar captures the flit at the end of the gnt cycle; the source advances on the next edge.
  - Because sel/gnt are registered and the source holds req until gnt, a granted body flit is re-granted no earlier than 2 cycles later. Back-to-back flits of one packet therefore transfer every other cycle.
- Candidate set for output o: C_o = {k : req_k && dst_k==o}. Each input targets exactly one output, so at most one gnt per input is possible.
- Per-output state machine, states IDLE and LOCKED(owner):
  - IDLE, C_o empty or out_rdy_o==0:
    - sel_o=0; stay IDLE; ptr_o unchanged.
  - IDLE, C_o non-empty and out_rdy_o==1:
    - Winner w = first member of C_o searching ptr_o, ptr_o+1, ptr_o+2 (mod 3).
    - Assert sel_o=onehot(w) and gnt_w; ptr_o <= (w+1) mod 3.
    - If tail_w: stay IDLE. Otherwise go to LOCKED(w).
  - LOCKED(w), req_w && dst_w==o && out_rdy_o:
    - sel_o=onehot(w), gnt_w=1.
    - If tail_w: go to IDLE. Otherwise stay LOCKED(w).
  - LOCKED(w), owner not requesting o or out_rdy_o==0:
    - sel_o=0, no grant, stay LOCKED(w).
    - Other candidates are blocked (wormhole); ptr_o unchanged.
  - Simultaneous tail grant and new requests: the output is free for arbitration at the next sampling edge. No bubble beyond the register latency.
- dst==3 with req: the request is never granted. dst_err pulses for each such sampled cycle.
- Invariant: at most one bit of each sel_o is set, and bits [SEL_W-1:3] are always 0.

Optional Feature:
- Macro: SA_STALL_CNT_EN.
- Defined:
  - Adds outputs stall_cnt0, stall_cnt1, stall_cnt2 (CNT_W each).
  - stall_cnt_k increments on every sampled cycle where req_k==1, dst_k is legal, and input k is not granted.
  - The counter saturates at all-ones and is cleared by reset.
- Undefined:
  - No counter ports and no counter logic; all other behaviour is identical.

Test Plan:
- Reset check: hold rst=0 for 2 cycles with all req=1 -> sel*=0, gnt*=0, dst_err=0. Release; single req0, dst0=2, tail0=1, out_rdy2=1 -> next cycle sel2=5'b00001, gnt0=1, sel0=sel1=0.
- Round-robin fairness: req0/1/2 all with dst=1, tail=1 every cycle, out_rdy1=1 -> sel1 sequence 00001, 00010, 00100, 00001 on grant cycles. Each input gets 1 grant per 3 grants.
- Wormhole lock: input1 sends a 3-flit packet to output 0 (tail on the 3rd flit) while input2 also requests output 0 -> sel0=00010 for all 3 input1 flits; input2 is granted only after input1's tail grant; sel0=00100 afterwards.
- Backpressure: a locked packet sees out_rdy0=0 for 4 cycles -> sel0=0, no gnt, lock held. out_rdy0 rises -> the owner resumes with the next flit and the competitor is still blocked.
- Illegal destination and parallel outputs: req0 dst0=3; req1 dst1=0; req2 dst2=1 -> dst_err=1 for one cycle, gnt0=0, sel0=00010, sel1=00100, gnt1=gnt2=1 in the same cycle.
- Reset mid-packet: rst=0 while output 2 is LOCKED(0) -> after reset, a fresh req1 dst1=2 is granted (sel2=00010) with no residual lock.
  - With SA_STALL_CNT_EN defined, stall_cnt* reads 0 after that reset.

Source files
------------

// File: rtl/ring_switch_allocator.sv
// ---------------------------------------------------------------------------
// ring_switch_allocator
//
// Per-cycle switch allocator for the 3-port ring router. Every output port
// runs its own round-robin arbiter. A multi-flit packet locks its output
// from the head flit to the tail flit (wormhole). The allocator produces
// registered one-hot crossbar selects and per-input grants.
//
// Ports
//   clk                 router clock
//   rst                 synchronous active-low reset, sampled on posedge clk
//   req0..req2          input k holds a valid flit
//   dst0..dst2  [1:0]   requested output of input k (3 is illegal)
//   tail0..tail2        current flit of input k is a tail (or single-flit)
//   out_rdy0..out_rdy2  downstream of output o can take a flit this cycle
//   sel0..sel2  [SEL_W] registered one-hot select; bit k = source input k
//   gnt0..gnt2          registered; flit on input k transfers this cycle
//   dst_err             registered pulse: some input requested dst==3
//   stall_cnt0..2       (only with SA_STALL_CNT_EN) saturating stall counts
//
// Optional feature macro: SA_STALL_CNT_EN adds the stall counters.
//
// Timing: inputs are sampled at edge t and sel/gnt appear in cycle t+1.
// The source keeps its flit and req up until the cycle in which it sees
// gnt, so at the edge that ends a grant cycle the allocator still sees the
// old (already transferred) flit. That request is masked, which is why
// flits of one packet move at most every other cycle.
// ---------------------------------------------------------------------------
module ring_switch_allocator #(
  parameter int SEL_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             req2,
  input  logic [1:0]       dst0,
  input  logic [1:0]       dst1,
  input  logic [1:0]       dst2,
  input  logic             tail0,
  input  logic             tail1,
  input  logic             tail2,
  input  logic             out_rdy0,
  input  logic             out_rdy1,
  input  logic             out_rdy2,
  output logic [SEL_W-1:0] sel0,
  output logic [SEL_W-1:0] sel1,
  output logic [SEL_W-1:0] sel2,
  output logic             gnt0,
  output logic             gnt1,
  output logic             gnt2,
`ifdef SA_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt0,
  output logic [CNT_W-1:0] stall_cnt1,
  output logic [CNT_W-1:0] stall_cnt2,
`endif
  output logic             dst_err
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Per-output arbitration state
  state_e          state_q [3];
  state_e          state_d [3];
  logic [2:0][1:0] owner_q, owner_d;
  logic [2:0][1:0] ptr_q,   ptr_d;

  // Registered outputs
  logic [2:0][2:0] sel_q, sel_d;
  logic [2:0]      gnt_q, gnt_d;
  logic            dst_err_q, dst_err_d;

  // Packed views of the per-input ports
  logic [2:0]      reqV;
  logic [2:0][1:0] dstV;
  logic [2:0]      tailV;
  logic [2:0]      rdyV;
  logic [2:0]      legalV;
  logic [2:0]      reqEff;
  logic [2:0][2:0] cand;

  assign reqV  = {req2, req1, req0};
  assign dstV  = {dst2, dst1, dst0};
  assign tailV = {tail2, tail1, tail0};
  assign rdyV  = {out_rdy2, out_rdy1, out_rdy0};

  // Round-robin search: first set bit of c starting at index p, wrapping mod 3.
  function automatic logic [1:0] rrPick(input logic [2:0] c, input logic [1:0] p);
    logic [1:0] res;
    logic       found;
    int         idx;
    res   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idx = (int'(p) + i) % 3;
      if (!found && c[idx]) begin
        res   = 2'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [1:0] rrNext(input logic [1:0] w);
    return (w == 2'd2) ? 2'd0 : w + 2'd1;
  endfunction

  // Candidate sets. A request whose flit is being transferred right now
  // (gnt_q high) is the stale copy of an already granted flit and is
  // ignored, as is any request to the illegal destination 3.
  always_comb begin
    legalV = '0;
    reqEff = '0;
    cand   = '0;
    for (int k = 0; k < 3; k++) begin
      legalV[k] = (dstV[k] != 2'd3);
      reqEff[k] = reqV[k] && legalV[k] && !gnt_q[k];
      for (int o = 0; o < 3; o++) begin
        cand[o][k] = reqEff[k] && (dstV[k] == 2'(o));
      end
    end
  end

  // Per-output next-state and grant decision. Each input targets only one
  // output, so the per-output grants never collide on a gnt bit.
  always_comb begin
    logic [1:0] w;
    w         = 2'd0;
    sel_d     = '0;
    gnt_d     = '0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    dst_err_d = |(reqV & ~legalV);
    for (int o = 0; o < 3; o++) begin
      state_d[o] = state_q[o];
      case (state_q[o])
        ST_IDLE: begin
          if ((cand[o] != 3'b000) && rdyV[o]) begin
            w            = rrPick(cand[o], ptr_q[o]);
            sel_d[o][w]  = 1'b1;
            gnt_d[w]     = 1'b1;
            ptr_d[o]     = rrNext(w);
            if (!tailV[w]) begin
              state_d[o] = ST_LOCKED;
              owner_d[o] = w;
            end
          end
        end
        ST_LOCKED: begin
          // Only the owner may proceed; everyone else waits for its tail.
          w = owner_q[o];
          if (cand[o][w] && rdyV[o]) begin
            sel_d[o][w] = 1'b1;
            gnt_d[w]    = 1'b1;
            if (tailV[w]) begin
              state_d[o] = ST_IDLE;
            end
          end
        end
        default: begin
          state_d[o] = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset drops every lock unconditionally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int o = 0; o < 3; o++) begin
        state_q[o] <= ST_IDLE;
      end
      owner_q   <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      dst_err_q <= 1'b0;
    end else begin
      for (int o = 0; o < 3; o++) begin
        state_q[o] <= state_d[o];
      end
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      dst_err_q <= dst_err_d;
    end
  end

  // Only the low three select bits carry sources; the rest are zero-filled.
  assign sel0    = SEL_W'(sel_q[0]);
  assign sel1    = SEL_W'(sel_q[1]);
  assign sel2    = SEL_W'(sel_q[2]);
  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign gnt2    = gnt_q[2];
  assign dst_err = dst_err_q;

`ifdef SA_STALL_CNT_EN
  logic [2:0][CNT_W-1:0] stall_q, stall_d;

  // A stall is a live legal request that lost this cycle. The cycle in
  // which the input's previous flit is being transferred is not a stall.
  always_comb begin
    stall_d = stall_q;
    for (int k = 0; k < 3; k++) begin
      if (reqV[k] && legalV[k] && !gnt_q[k] && !gnt_d[k] &&
          (stall_q[k] != {CNT_W{1'b1}})) begin
        stall_d[k] = stall_q[k] + CNT_W'(1);
      end
    end
  end

  // Saturating counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt0 = stall_q[0];
  assign stall_cnt1 = stall_q[1];
  assign stall_cnt2 = stall_q[2];
`endif

endmodule

// File: tb/tb_ring_switch_allocator.sv
// ---------------------------------------------------------------------------
// tb_ring_switch_allocator
//
// Directed bench for ring_switch_allocator. The driver applies one input
// vector per cycle and queues the hand-computed outputs expected after the
// next clock edge; an independent monitor pops one entry per cycle and
// compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_ring_switch_allocator;

  localparam int SEL_W = 5;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             req0, req1, req2;
  logic [1:0]       dst0, dst1, dst2;
  logic             tail0, tail1, tail2;
  logic             out_rdy0, out_rdy1, out_rdy2;
  logic [SEL_W-1:0] sel0, sel1, sel2;
  logic             gnt0, gnt1, gnt2;
  logic             dst_err;
`ifdef SA_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt0, stall_cnt1, stall_cnt2;
`endif

  int checks;
  int errors;

  typedef struct {
    logic [SEL_W-1:0] s0;
    logic [SEL_W-1:0] s1;
    logic [SEL_W-1:0] s2;
    logic [2:0]       g;
    logic             e;
    string            name;
  } exp_t;

  exp_t expQ[$];

  ring_switch_allocator #(.SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .req2(req2),
    .dst0(dst0), .dst1(dst1), .dst2(dst2),
    .tail0(tail0), .tail1(tail1), .tail2(tail2),
    .out_rdy0(out_rdy0), .out_rdy1(out_rdy1), .out_rdy2(out_rdy2),
    .sel0(sel0), .sel1(sel1), .sel2(sel2),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
`ifdef SA_STALL_CNT_EN
    .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1), .stall_cnt2(stall_cnt2),
`endif
    .dst_err(dst_err)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one vector on the falling edge and queue the outputs expected
  // after the following rising edge. Vectors are {in2,in1,in0}.
  task automatic applyStimulus(input logic rstN, input logic [2:0] req,
                               input logic [1:0] d2, input logic [1:0] d1,
                               input logic [1:0] d0, input logic [2:0] tail,
                               input logic [2:0] rdy, input logic [2:0] es0,
                               input logic [2:0] es1, input logic [2:0] es2,
                               input logic [2:0] eg, input logic ee,
                               input string name);
    exp_t x;
    @(negedge clk);
    rst = rstN;
    {req2, req1, req0}             = req;
    dst2 = d2; dst1 = d1; dst0 = d0;
    {tail2, tail1, tail0}          = tail;
    {out_rdy2, out_rdy1, out_rdy0} = rdy;
    x.s0 = SEL_W'(es0);
    x.s1 = SEL_W'(es1);
    x.s2 = SEL_W'(es2);
    x.g  = eg;
    x.e  = ee;
    x.name = name;
    expQ.push_back(x);
  endtask

  task automatic checkOutput(input exp_t x);
    logic [3*SEL_W+3:0] act, req;
    act = {sel2, sel1, sel0, gnt2, gnt1, gnt0, dst_err};
    req = {x.s2, x.s1, x.s0, x.g, x.e};
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got sel2=%b sel1=%b sel0=%b gnt=%b err=%b, want sel2=%b sel1=%b sel0=%b gnt=%b err=%b",
               x.name, sel2, sel1, sel0, {gnt2, gnt1, gnt0}, dst_err,
               x.s2, x.s1, x.s0, x.g, x.e);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        x = expQ.pop_front();
        checkOutput(x);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    {req2, req1, req0} = 3'b000;
    dst0 = 2'd0; dst1 = 2'd0; dst2 = 2'd0;
    {tail2, tail1, tail0} = 3'b000;
    {out_rdy2, out_rdy1, out_rdy0} = 3'b111;

    // Reset held with everyone requesting
    applyStimulus(0, 3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, "reset_a");
    applyStimulus(0, 3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, "reset_b");

    // First single-flit grant after reset; ptr2 moves to 1
    applyStimulus(1, 3'b001, 2'd0, 2'd0, 2'd2, 3'b001, 3'b111, 3'b000, 3'b000, 3'b001, 3'b001, 0, "first_grant");
    applyStimulus(1, 3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, "idle_1");

    // Round robin on output 1, single-flit packets; granted input is masked
    applyStimulus(1, 3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 3'b111, 3'b000, 3'b001, 3'b000, 3'b001, 0, "rr_0");
    applyStimulus(1, 3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 3'b111, 3'b000, 3'b010, 3'b000, 3'b010, 0, "rr_1");
    applyStimulus(1, 3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 3'b111, 3'b000, 3'b100, 3'b000, 3'b100, 0, "rr_2");
    applyStimulus(1, 3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 3'b111, 3'b000, 3'b001, 3'b000, 3'b001, 0, "rr_3");
    applyStimulus(1, 3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, "idle_2");

    // Wormhole: input1 3-flit packet to out0, input2 single flit competing
    applyStimulus(1, 3'b110, 2'd0, 2'd0, 2'd0, 3'b100, 3'b111, 3'b010, 3'b000, 3'b000, 3'b010, 0, "worm_head");
    applyStimulus(1, 3'b110, 2'd0, 2'd0, 2'd0, 3'b100, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, "worm_hold1");
    applyStimulus(1, 3'b110, 2'd0, 2'd0, 2'd0, 3'b100, 3'b111, 3'b010, 3'b000, 3'b000, 3'b010, 0, "worm_body");
    applyStimulus(1, 3'b110, 2'd0, 2'd0, 2'd0, 3'b100, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, "worm_hold2");
    applyStimulus(1, 3'b110, 2'd0, 2'd0, 2'd0, 3'b110, 3'b111, 3'b010, 3'b000, 3'b000, 3'b010, 0, "worm_tail");
    applyStimulus(1, 3'b110, 2'd0, 2'd0, 2'd0, 3'b110, 3'b111, 3'b100, 3'b000, 3'b000, 3'b100, 0, "worm_next");
    applyStimulus(1, 3'b100, 2'd0, 2'd0, 2'd0, 3'b100, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, "worm_drain");

    // Backpressure: input0 locks out0 (ptr0=0), input1 waits behind it
    applyStimulus(1, 3'b011, 2'd0, 2'd0, 2'd0, 3'b010, 3'b111, 3'b001, 3'b000, 3'b000, 3'b001, 0, "bp_head");
    applyStimulus(1, 3'b011, 2'd0, 2'd0, 2'd0, 3'b010, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 0, "bp_stall1");
    applyStimulus(1, 3'b011, 2'd0, 2'd0, 2'd0, 3'b011, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 0, "bp_stall2");
    applyStimulus(1, 3'b011, 2'd0, 2'd0, 2'd0, 3'b011, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 0, "bp_stall3");
    applyStimulus(1, 3'b011, 2'd0, 2'd0, 2'd0, 3'b011, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 0, "bp_stall4");
    applyStimulus(1, 3'b011, 2'd0, 2'd0, 2'd0, 3'b011, 3'b111, 3'b001, 3'b000, 3'b000, 3'b001, 0, "bp_resume");
    applyStimulus(1, 3'b011, 2'd0, 2'd0, 2'd0, 3'b011, 3'b111, 3'b010, 3'b000, 3'b000, 3'b010, 0, "bp_competitor");
    applyStimulus(1, 3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, "idle_3");

    // Illegal destination plus two outputs granting in parallel
    applyStimulus(1, 3'b111, 2'd1, 2'd0, 2'd3, 3'b111, 3'b111, 3'b010, 3'b100, 3'b000, 3'b110, 1, "dst_err_par");
    applyStimulus(1, 3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, "dst_err_drop");

    // Reset mid-packet: input0 locks out2 (ptr2=1 searches 1,2,0)
    applyStimulus(1, 3'b001, 2'd0, 2'd0, 2'd2, 3'b000, 3'b111, 3'b000, 3'b000, 3'b001, 3'b001, 0, "mid_lock");
    applyStimulus(0, 3'b001, 2'd0, 2'd0, 2'd2, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, "mid_reset");
`ifdef SA_STALL_CNT_EN
    @(posedge clk);
    #2;
    checks++;
    if ({stall_cnt2, stall_cnt1, stall_cnt0} !== '0) begin
      errors++;
      $display("[TB] FAIL stall_after_reset: got %0d %0d %0d, want 0 0 0",
               stall_cnt2, stall_cnt1, stall_cnt0);
    end
`endif
    applyStimulus(1, 3'b010, 2'd0, 2'd2, 2'd0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b010, 3'b010, 0, "post_reset_grant");
    // New lock by input1 now blocks input0 on out2
    applyStimulus(1, 3'b011, 2'd0, 2'd2, 2'd2, 3'b001, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, "post_reset_lock");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: got %0d pending entries, want 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
